edge_frame_seq: RTL and testbench

//   Frame sequencer and threshold controller for the gradient/edge_det datapath.
//   On start it scans one frame:
//     - issues grayscale read addresses;
//     - tracks the fixed pipeline latency;
//     - writes each pixel_edge bit to the edge-map BRAM;
//     - counts edge pixels.

---
 rtl/edge_frame_seq.sv | 181 ++++++++++++++++++
 tb/tb_edge_frame_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_seq.sv
// Frame sequencer and adaptive threshold controller for the gradient/edge_det datapath.
// One frame: sweep grayscale read addresses, follow the fixed pipeline latency, write each
// pixel_edge bit into the edge-map BRAM, count edge pixels, then nudge the threshold so the
// per-frame edge count moves toward target_count.
module edge_frame_seq #(
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIPE_LAT = 3,
  parameter logic [15:0] THR_INIT = 16'd400,
  parameter logic [15:0] THR_STEP = 16'd8,
  parameter logic [16:0] HYST     = 17'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adapt_en,
  input  logic [16:0]       target_count,
  input  logic              pixel_edge,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic [15:0]       threshold,
  output logic [16:0]       edge_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       NumPix   = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDrain,
    StUpdate,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Scan address counter.
  logic [ADDR_W-1:0] addr_q;

  // Delay line aligning each read address with its returning pixel_edge bit.
  logic              dly_valid_q [PIPE_LAT];
  logic [ADDR_W-1:0] dly_addr_q  [PIPE_LAT];
  logic              dly_last_valid;
  logic [ADDR_W-1:0] dly_last_addr;
  logic              dly_pending;

  logic [15:0] thr_q;
  logic [15:0] thr_next;
  logic [16:0] count_q;

  logic frame_start;

  assign frame_start    = (state_q == StIdle) && start;
  assign dly_last_valid = dly_valid_q[PIPE_LAT-1];
  assign dly_last_addr  = dly_addr_q[PIPE_LAT-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending reads still inside the line, excluding the stage that writes this cycle.
  always_comb begin
    dly_pending = 1'b0;
    for (int unsigned i = 0; i + 1 < PIPE_LAT; i++) begin
      dly_pending = dly_pending | dly_valid_q[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StScan;
      end
      StScan: begin
        if (addr_q == LastAddr) state_d = StDrain;
      end
      StDrain: begin
        // Leave once the final write happens on this edge.
        if (!dly_pending) state_d = StUpdate;
      end
      StUpdate: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode; addresses are forced to zero whenever their strobe is low.
  always_comb begin
    rd_en   = (state_q == StScan);
    rd_addr = rd_en ? addr_q : '0;
    wr_en   = dly_last_valid;
    wr_addr = dly_last_valid ? dly_last_addr : '0;
    wr_data = dly_last_valid & pixel_edge;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  // Read address counter: cleared on frame entry, advanced every SCAN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (frame_start) begin
      addr_q <= '0;
    end else if (state_q == StScan) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Delay line shift: stage 0 captures the current read, later stages follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        dly_valid_q[i] <= 1'b0;
        dly_addr_q[i]  <= '0;
      end
    end else begin
      dly_valid_q[0] <= rd_en;
      dly_addr_q[0]  <= rd_addr;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        dly_valid_q[i] <= dly_valid_q[i-1];
        dly_addr_q[i]  <= dly_addr_q[i-1];
      end
    end
  end

  // Edge pixel counter: cleared on frame entry, held after the frame until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (frame_start) begin
      count_q <= '0;
    end else if (dly_last_valid && pixel_edge) begin
      count_q <= count_q + 17'd1;
    end
  end

  // Threshold adaptation rule, evaluated in 18 bits so target+HYST cannot overflow.
  always_comb begin
    logic [17:0] cnt_ext;
    logic [17:0] tgt_ext;
    logic [17:0] hyst_ext;
    logic [16:0] thr_sum;
    cnt_ext  = {1'b0, count_q};
    tgt_ext  = {1'b0, target_count};
    hyst_ext = {1'b0, HYST};
    thr_sum  = {1'b0, thr_q} + {1'b0, THR_STEP};
    thr_next = thr_q;
    if (cnt_ext > tgt_ext + hyst_ext) begin
      thr_next = thr_sum[16] ? 16'hFFFF : thr_sum[15:0];
    end else if (cnt_ext + hyst_ext < tgt_ext) begin
      thr_next = (thr_q < THR_STEP) ? 16'h0000 : thr_q - THR_STEP;
    end
  end

  // Threshold register: only moves in UPDATE, so it is stable across a frame's writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= THR_INIT;
    end else if ((state_q == StUpdate) && adapt_en) begin
      thr_q <= thr_next;
    end
  end

  assign threshold  = thr_q;
  assign edge_count = count_q;

endmodule

// File: tb/tb_edge_frame_seq.sv
// Self-checking bench for edge_frame_seq on a 4x3 frame with PIPE_LAT=3.
// Three instances share all inputs and differ only in THR_INIT (100, 2, 16'hFFFE) so the
// threshold floor and ceiling are reached without long adaptation runs.
module tb_edge_frame_seq;

  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int N    = IW * IH;
  localparam int PL   = 3;
  localparam int STEP = 4;
  localparam int HY   = 1;
  localparam int L    = N + PL + 3;  // samples per frame, last one back in IDLE

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic adapt_en;
  logic [16:0] target_count;
  logic pixel_edge;

  logic        rd_en, wr_en, wr_data, busy, done;
  logic [16:0] rd_addr, wr_addr, edge_count;
  logic [15:0] threshold;

  logic        lo_rd_en, lo_wr_en, lo_wr_data, lo_busy, lo_done;
  logic [16:0] lo_rd_addr, lo_wr_addr, lo_edge_count;
  logic [15:0] lo_threshold;

  logic        hi_rd_en, hi_wr_en, hi_wr_data, hi_busy, hi_done;
  logic [16:0] hi_rd_addr, hi_wr_addr, hi_edge_count;
  logic [15:0] hi_threshold;

  int n_checks = 0;
  int n_errors = 0;
  int thr_m [3];
  int thr_init [3] = '{100, 2, 65534};

  always #5 clk = ~clk;

  edge_frame_seq #(
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(17), .PIPE_LAT(PL),
    .THR_INIT(16'd100), .THR_STEP(16'd4), .HYST(17'd1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .adapt_en(adapt_en),
    .target_count(target_count), .pixel_edge(pixel_edge),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .threshold(threshold), .edge_count(edge_count),
    .busy(busy), .done(done)
  );

  edge_frame_seq #(
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(17), .PIPE_LAT(PL),
    .THR_INIT(16'd2), .THR_STEP(16'd4), .HYST(17'd1)
  ) dut_lo (
    .clk(clk), .rst(rst), .start(start), .adapt_en(adapt_en),
    .target_count(target_count), .pixel_edge(pixel_edge),
    .rd_en(lo_rd_en), .rd_addr(lo_rd_addr), .wr_en(lo_wr_en), .wr_addr(lo_wr_addr),
    .wr_data(lo_wr_data), .threshold(lo_threshold), .edge_count(lo_edge_count),
    .busy(lo_busy), .done(lo_done)
  );

  edge_frame_seq #(
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(17), .PIPE_LAT(PL),
    .THR_INIT(16'hFFFE), .THR_STEP(16'd4), .HYST(17'd1)
  ) dut_hi (
    .clk(clk), .rst(rst), .start(start), .adapt_en(adapt_en),
    .target_count(target_count), .pixel_edge(pixel_edge),
    .rd_en(hi_rd_en), .rd_addr(hi_rd_addr), .wr_en(hi_wr_en), .wr_addr(hi_wr_addr),
    .wr_data(hi_wr_data), .threshold(hi_threshold), .edge_count(hi_edge_count),
    .busy(hi_busy), .done(hi_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule: move by STEP when outside the dead band, clamp to 0..65535.
  function automatic int next_thr(input int t, input int cnt, input int tgt, input bit adapt);
    int r;
    r = t;
    if (adapt) begin
      if (cnt > tgt + HY) r = t + STEP;
      else if (cnt + HY < tgt) r = t - STEP;
    end
    if (r > 65535) r = 65535;
    if (r < 0) r = 0;
    return r;
  endfunction

  // Runs one frame from the negedge before its start edge (start already high).
  // hold keeps start high throughout; poke pulses start during SCAN.
  task automatic run_frame(input bit hold, input bit poke, input bit adapt, input int tgt,
                           input logic [N-1:0] pe);
    int  ones;
    int  cnt_exp;
    int  new_thr [3];
    bit  er, ew;
    logic pix;
    adapt_en     = adapt;
    target_count = 17'(tgt);
    ones = 0;
    for (int a = 0; a < N; a++) ones += int'(pe[a]);
    for (int i = 0; i < 3; i++) new_thr[i] = next_thr(thr_m[i], ones, tgt, adapt);
    cnt_exp = 0;
    for (int j = 1; j <= L; j++) begin
      @(posedge clk);
      @(negedge clk);
      start = hold || (poke && j == 5);
      er    = (j <= N);
      ew    = (j >= PL + 1) && (j <= N + PL);
      pix   = ew ? pe[j-1-PL] : 1'($urandom_range(0, 1));
      pixel_edge = pix;
      #1;
      check("rd_en", rd_en, er);
      check("rd_addr", rd_addr, er ? j - 1 : 0);
      check("wr_en", wr_en, ew);
      check("wr_addr", wr_addr, ew ? j - 1 - PL : 0);
      check("wr_data", wr_data, ew & pix);
      check("done", done, j == N + PL + 2);
      check("busy", busy, j <= N + PL + 2);
      check("threshold", threshold, (j <= N + PL + 1) ? thr_m[0] : new_thr[0]);
      check("edge_count", edge_count, cnt_exp);
      if (ew && pix) cnt_exp++;
    end
    check("lo_threshold", lo_threshold, new_thr[1]);
    check("hi_threshold", hi_threshold, new_thr[2]);
    check("lo_edge_count", lo_edge_count, ones);
    check("hi_edge_count", hi_edge_count, ones);
    for (int i = 0; i < 3; i++) thr_m[i] = new_thr[i];
  endtask

  typedef struct {
    bit hold;
    bit poke;
    bit adapt;
    int tgt;
    bit ones;       // 1: every pixel is an edge, 0: none
    int exp_count;
    int exp_thr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pe;

    tbl[0] = '{1'b1, 1'b0, 1'b1,  2, 1'b1, 12, 104};  // back-to-back into next row
    tbl[1] = '{1'b0, 1'b1, 1'b1, 20, 1'b0,  0, 100};  // start poked while busy
    tbl[2] = '{1'b0, 1'b0, 1'b1, 20, 1'b0,  0,  96};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 12, 1'b1, 12,  96};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 11, 1'b1, 12,  96};  // count == target+HYST: hold
    tbl[5] = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 12, 100};
    tbl[6] = '{1'b0, 1'b0, 1'b1,  1, 1'b0,  0, 100};  // count+HYST == target: hold
    tbl[7] = '{1'b0, 1'b0, 1'b1,  2, 1'b0,  0,  96};
    tbl[8] = '{1'b0, 1'b0, 1'b0,  2, 1'b1, 12,  96};  // adapt disabled

    // Reset hold.
    rst = 1'b1; start = 1'b0; adapt_en = 1'b1; target_count = '0; pixel_edge = 1'b1;
    for (int i = 0; i < 3; i++) thr_m[i] = thr_init[i];
    repeat (3) @(negedge clk);
    check("rst_threshold", threshold, 100);
    check("rst_lo_threshold", lo_threshold, 2);
    check("rst_hi_threshold", hi_threshold, 16'hFFFE);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_edge_count", edge_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rd_en", rd_en, 0);

    // Directed table.
    for (int r = 0; r < 9; r++) begin
      pe = tbl[r].ones ? {N{1'b1}} : '0;
      start = 1'b1;
      run_frame(tbl[r].hold, tbl[r].poke, tbl[r].adapt, tbl[r].tgt, pe);
      check($sformatf("tbl%0d_count", r), edge_count, tbl[r].exp_count);
      check($sformatf("tbl%0d_thr", r), threshold, tbl[r].exp_thr);
    end

    // Reset mid-scan, then a fresh frame must restart from address 0.
    start = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      pixel_edge = 1'b1;
    end
    #1;
    check("pre_rst_count", edge_count, 1);
    check("pre_rst_rd_en", rd_en, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_rd_en", rd_en, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_count", edge_count, 0);
    check("midrst_threshold", threshold, 100);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) thr_m[i] = thr_init[i];
    start = 1'b1;
    run_frame(1'b0, 1'b0, 1'b1, 30, 12'hA5C);

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       pe = '0;
        1:       pe = {N{1'b1}};
        default: pe = N'($urandom);
      endcase
      start = 1'b1;
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 16)), pe);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
